// File: rtl/hdmi_rx_timing_monitor.sv
// ADV7611 input stage: registers the pixel bus, measures line width and frame height,
// locks after LOCK_FRAMES consecutive good frames and streams flagged pixels only while locked.
module hdmi_rx_timing_monitor #(
    parameter int H_ACTIVE      = 1920,
    parameter int V_ACTIVE      = 1080,
    parameter bit VS_POL        = 1'b1,
    parameter int LOCK_FRAMES   = 3,
    parameter int FRAME_TIMEOUT = 2500000
) (
    input  logic        hdmi_pclk_i,
    input  logic        rst,
    input  logic [23:0] hdmi_data_i,
    input  logic        hdmi_de_i,
    input  logic        hdmi_hs_i,
    input  logic        hdmi_vs_i,
    output logic [23:0] pix_data_o,
    output logic        pix_valid_o,
    output logic        pix_sof_o,
    output logic        pix_eol_o,
    output logic        locked_o,
    output logic [11:0] meas_width_o,
    output logic [11:0] meas_height_o,
    output logic [7:0]  err_cnt_o
);

    localparam int             TO_W    = $clog2(FRAME_TIMEOUT + 1);
    localparam logic [11:0]    H_ACT   = 12'(H_ACTIVE);
    localparam logic [11:0]    V_ACT   = 12'(V_ACTIVE);
    localparam logic [3:0]     LOCK_N  = 4'(LOCK_FRAMES);
    localparam logic [3:0]     LOCK_M1 = 4'(LOCK_FRAMES - 1);
    localparam logic [TO_W-1:0] TO_MAX  = TO_W'(FRAME_TIMEOUT);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(FRAME_TIMEOUT - 1);

    function automatic logic [11:0] sat_inc12(input logic [11:0] v);
        return (v == 12'hFFF) ? v : v + 12'd1;
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    logic [23:0]     data_p1;
    logic            de_p1, vs_p1, hs_unused_p1;
    logic            de_p2, vs_p2;
    logic [11:0]     pix_cnt, line_cnt, line_cnt_nxt;
    logic            bad_flag, bad_nxt;
    logic            frame_seen, sof_pending;
    logic [3:0]      good_cnt;
    logic [TO_W-1:0] to_cnt;
    logic            fs, de_rise, de_fall, frame_good, timeout;

    // stage 1: register the raw bus
    always_ff @(posedge hdmi_pclk_i) begin
        data_p1      <= hdmi_data_i;
        hs_unused_p1 <= hdmi_hs_i;
        if (rst) begin
            de_p1 <= 1'b0;
            vs_p1 <= VS_POL;
        end else begin
            de_p1 <= hdmi_de_i;
            vs_p1 <= hdmi_vs_i;
        end
    end

    always_comb begin
        fs           = (vs_p1 == VS_POL) && (vs_p2 != VS_POL);
        de_rise      = de_p1 && !de_p2;
        de_fall      = !de_p1 && de_p2;
        line_cnt_nxt = line_cnt;
        bad_nxt      = bad_flag;
        // a line ending on the frame-start cycle still belongs to the frame being closed
        if (de_fall) begin
            line_cnt_nxt = sat_inc12(line_cnt);
            if (pix_cnt != H_ACT)
                bad_nxt = 1'b1;
        end
        frame_good = !bad_nxt && (line_cnt_nxt == V_ACT);
        // no frame start seen since reset/timeout means there is no lock to lose
        timeout    = frame_seen && !fs && (to_cnt == TO_LAST);
    end

    // stage 2: output pipeline and timing measurement
    always_ff @(posedge hdmi_pclk_i) begin
        if (rst) begin
            de_p2         <= 1'b0;
            vs_p2         <= VS_POL;
            pix_data_o    <= '0;
            pix_cnt       <= '0;
            line_cnt      <= '0;
            bad_flag      <= 1'b0;
            frame_seen    <= 1'b0;
            sof_pending   <= 1'b0;
            good_cnt      <= '0;
            to_cnt        <= '0;
            locked_o      <= 1'b0;
            meas_width_o  <= '0;
            meas_height_o <= '0;
            err_cnt_o     <= '0;
        end else begin
            de_p2      <= de_p1;
            vs_p2      <= vs_p1;
            pix_data_o <= data_p1;

            if (de_rise)
                pix_cnt <= 12'd1;
            else if (de_p1)
                pix_cnt <= sat_inc12(pix_cnt);
            if (de_fall)
                meas_width_o <= pix_cnt;

            if (fs)
                sof_pending <= 1'b1;
            else if (pix_sof_o)
                sof_pending <= 1'b0;

            if (fs) begin
                to_cnt   <= '0;
                line_cnt <= '0;
                bad_flag <= 1'b0;
                if (!frame_seen) begin
                    frame_seen <= 1'b1;
                end else begin
                    meas_height_o <= line_cnt_nxt;
                    if (frame_good) begin
                        if (good_cnt != LOCK_N)
                            good_cnt <= good_cnt + 4'd1;
                        if (good_cnt >= LOCK_M1)
                            locked_o <= 1'b1;
                    end else begin
                        good_cnt  <= '0;
                        locked_o  <= 1'b0;
                        err_cnt_o <= sat_inc8(err_cnt_o);
                    end
                end
            end else begin
                line_cnt <= line_cnt_nxt;
                bad_flag <= bad_nxt;
                if (to_cnt != TO_MAX)
                    to_cnt <= to_cnt + TO_W'(1);
                if (timeout) begin
                    locked_o   <= 1'b0;
                    good_cnt   <= '0;
                    frame_seen <= 1'b0;
                    err_cnt_o  <= sat_inc8(err_cnt_o);
                end
            end
        end
    end

    assign pix_valid_o = de_p2 && locked_o;
    assign pix_sof_o   = pix_valid_o && sof_pending;
    assign pix_eol_o   = pix_valid_o && !de_p1;

endmodule
